stopwatch_counter: RTL

Timekeeping datapath driven by the stopwatch control FSM. Consumes `running`, `direction` and `clear_pulse`, and returns `at_zero` to the controller. Divides the 100 MHz system clock down to a 1 Hz count tick and maintains an MM:SS BCD count (00:00–59:59) that counts up or down. Supports a preset load for count-down mode, and feeds the 4-digit seven-segment display driver.

---
 rtl/stopwatch_counter_if.sv | 25 ++
 rtl/stopwatch_counter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stopwatch_counter_if.sv
// Control/status bundle between the stopwatch controller and the counter datapath.
interface stopwatch_counter_if;
  logic        running;
  logic        direction;
  logic        clear_pulse;
  logic        load;
  logic [15:0] preset_bcd;
  logic [15:0] bcd;
  logic        at_zero;
  logic        tick;
  logic        wrap;
  logic        expire;

  // Controller side: drives commands, observes the count.
  modport master (
    output running, direction, clear_pulse, load, preset_bcd,
    input  bcd, at_zero, tick, wrap, expire
  );

  // Counter side: consumes commands, returns the count.
  modport slave (
    input  running, direction, clear_pulse, load, preset_bcd,
    output bcd, at_zero, tick, wrap, expire
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping datapath: prescaler down to the count rate and an
// MM:SS BCD up/down counter with preset load, clear and status pulses.
module stopwatch_counter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic               clock,
  input  logic               reset,
  stopwatch_counter_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [15:0]   bcd_q;
  logic          tick_q;
  logic          wrap_q;
  logic          expire_q;

  logic [3:0]    s0, s1, m0, m1;
  logic          step;
  logic [15:0]   up_bcd;
  logic          up_wrap;
  logic [15:0]   dn_bcd;
  logic          dn_expire;

  // Per-digit clamp of an out-of-range preset: units to 9, tens to 5.
  function automatic logic [15:0] clamp_preset(input logic [15:0] p);
    logic [3:0] c_m1, c_m0, c_s1, c_s0;
    c_m1 = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
    c_m0 = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    c_s1 = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    c_s0 = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {c_m1, c_m0, c_s1, c_s0};
  endfunction

  assign s0   = bcd_q[3:0];
  assign s1   = bcd_q[7:4];
  assign m0   = bcd_q[11:8];
  assign m1   = bcd_q[15:12];
  assign step = bus.running && (presc == PRESC_LAST);

  // Incremented count with digit carries; wrap flags the 59:59 rollover.
  always_comb begin
    up_bcd  = bcd_q;
    up_wrap = 1'b0;
    if (s0 != 4'd9) begin
      up_bcd[3:0] = s0 + 4'd1;
    end else begin
      up_bcd[3:0] = '0;
      if (s1 != 4'd5) begin
        up_bcd[7:4] = s1 + 4'd1;
      end else begin
        up_bcd[7:4] = '0;
        if (m0 != 4'd9) begin
          up_bcd[11:8] = m0 + 4'd1;
        end else begin
          up_bcd[11:8] = '0;
          if (m1 != 4'd5) begin
            up_bcd[15:12] = m1 + 4'd1;
          end else begin
            up_bcd[15:12] = '0;
            up_wrap       = 1'b1;
          end
        end
      end
    end
  end

  // Decremented count with digit borrows; saturates at 00:00.
  always_comb begin
    dn_bcd    = bcd_q;
    dn_expire = 1'b0;
    if (bcd_q != '0) begin
      if (s0 != 4'd0) begin
        dn_bcd[3:0] = s0 - 4'd1;
      end else begin
        dn_bcd[3:0] = 4'd9;
        if (s1 != 4'd0) begin
          dn_bcd[7:4] = s1 - 4'd1;
        end else begin
          dn_bcd[7:4] = 4'd5;
          if (m0 != 4'd0) begin
            dn_bcd[11:8] = m0 - 4'd1;
          end else begin
            dn_bcd[11:8]  = 4'd9;
            dn_bcd[15:12] = m1 - 4'd1;
          end
        end
      end
      dn_expire = (bcd_q == 16'h0001);
    end
  end

  // Prescaler, count register and one-cycle status pulses; clear > load > step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      bcd_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      expire_q <= 1'b0;
      if (bus.running) begin
        presc <= step ? '0 : presc + 1'b1;
      end
      if (bus.clear_pulse) begin
        bcd_q <= '0;
        presc <= '0;
      end else if (bus.load && !bus.running) begin
        bcd_q <= clamp_preset(bus.preset_bcd);
        presc <= '0;
      end else if (step) begin
        tick_q <= 1'b1;
        if (bus.direction) begin
          bcd_q  <= up_bcd;
          wrap_q <= up_wrap;
        end else begin
          bcd_q    <= dn_bcd;
          expire_q <= dn_expire;
        end
      end
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.at_zero = (bcd_q == '0);
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.expire  = expire_q;

endmodule
